// File: rtl/mini8086_pkg.sv
// Shared types and address-map constants for the Mini8086 chipset glue blocks.
package mini8086_pkg;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_VGA,
        RGN_ROM,
        RGN_IO
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_WAIT,
        ST_EXT,
        ST_HOLD
    } ws_state_e;

    // ADDR[19:16] boundaries: upper RAM bank, video window, BIOS ROM.
    localparam logic [3:0] RAM_HI_BASE = 4'h8;
    localparam logic [3:0] VGA_BASE    = 4'hC;
    localparam logic [3:0] ROM_BASE    = 4'hE;

    function automatic region_e region_of(input logic m_io, input logic [3:0] addr_hi);
        region_e r;
        r = RGN_IO;
        if (m_io) begin
            case (addr_hi) inside
                [4'h0 : RAM_HI_BASE - 4'h1],
                [RAM_HI_BASE : VGA_BASE - 4'h1]: r = RGN_RAM;
                [VGA_BASE : ROM_BASE - 4'h1]:    r = RGN_VGA;
                default:                         r = RGN_ROM;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ws_watchdog.sv
// Clock counter that bounds the external (VGA_RDY) wait phase of wait_state_gen.
// Compiled only when WS_TIMEOUT_EN is defined.
`ifdef WS_TIMEOUT_EN
module ws_watchdog
    import mini8086_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic RESET_N,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam logic [7:0] LastCount = 8'(LIMIT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run && (count_q != LastCount)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the LIMIT-th clock spent in the external-wait phase.
    assign expired = run && (count_q == LastCount);

endmodule
`endif

// File: rtl/wait_state_gen.sv
// Programmable READY generator: per-region wait states plus VGA_RDY stretching.
// Define WS_TIMEOUT_EN to add a watchdog on the VGA_RDY wait and the sticky TIMEOUT_FLAG.
module wait_state_gen
    import mini8086_pkg::*;
#(
    parameter int RAM_WS      = 0,
    parameter int VGA_WS      = 2,
    parameter int ROM_WS      = 1,
    parameter int IO_WS       = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       ALE,
    input  logic       M_IO,
    input  logic       RD,
    input  logic       WR,
    input  logic       INTA,
    input  logic [3:0] ADDR_HI,
    input  logic       VGA_RDY,
    output logic       RDY1,
    output logic       TIMEOUT_FLAG,
    output logic       WS_ACTIVE
);

    localparam logic [7:0] RamWs = 8'(RAM_WS);
    localparam logic [7:0] VgaWs = 8'(VGA_WS);
    localparam logic [7:0] RomWs = 8'(ROM_WS);
    localparam logic [7:0] IoWs  = 8'(IO_WS);

    if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
        $error("wait_state_gen: TIMEOUT_CYC must lie in 2..255");
    end

    ws_state_e  state_q, state_d;
    region_e    region_q, region_d;
    region_e    new_region;
    logic [7:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;
    logic       ws_active_q;
    logic       cmd;
    logic       vga_stall;
    logic       expired;

    function automatic logic [7:0] ws_of(input region_e r);
        logic [7:0] w;
        case (r)
            RGN_RAM: w = RamWs;
            RGN_VGA: w = VgaWs;
            RGN_ROM: w = RomWs;
            default: w = IoWs;
        endcase
        return w;
    endfunction

    assign cmd        = ~RD | ~WR | ~INTA;
    assign new_region = region_of(M_IO, ADDR_HI);
    assign vga_stall  = (region_q == RGN_VGA) && !VGA_RDY;

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        rdy_d    = rdy_q;
        case (state_q)
            ST_IDLE: begin
                rdy_d = 1'b1;
                if (ALE) begin
                    region_d = new_region;
                    cnt_d    = ws_of(new_region);
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A second ALE before any strobe means the CPU restarted the cycle.
                if (ALE) begin
                    region_d = new_region;
                    cnt_d    = ws_of(new_region);
                end else if (cmd) begin
                    if (cnt_q != 8'd0) begin
                        rdy_d   = 1'b0;
                        state_d = ST_WAIT;
                    end else if (vga_stall) begin
                        rdy_d   = 1'b0;
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    cnt_d = 8'd0;
                    if (vga_stall) begin
                        state_d = ST_EXT;
                    end else begin
                        rdy_d   = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_EXT: begin
                if (VGA_RDY || expired) begin
                    rdy_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                rdy_d = 1'b1;
                if (!cmd) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            region_q    <= RGN_RAM;
            cnt_q       <= '0;
            rdy_q       <= 1'b1;
            ws_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
            ws_active_q <= (state_d == ST_WAIT) || (state_d == ST_EXT);
        end
    end

`ifdef WS_TIMEOUT_EN
    logic ext_run;
    logic ext_enter;
    logic timeout_q;

    assign ext_run   = (state_q == ST_EXT);
    assign ext_enter = (state_d == ST_EXT) && (state_q != ST_EXT);

    ws_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .RESET_N (RESET_N),
        .run     (ext_run),
        .clr     (ext_enter),
        .expired (expired)
    );

    // A genuine VGA_RDY on the same clock as expiry completes normally.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            timeout_q <= 1'b0;
        end else if (ext_run && expired && !VGA_RDY) begin
            timeout_q <= 1'b1;
        end
    end

    assign TIMEOUT_FLAG = timeout_q;
`else
    assign expired      = 1'b0;
    assign TIMEOUT_FLAG = 1'b0;
`endif

    assign RDY1      = rdy_q;
    assign WS_ACTIVE = ws_active_q;

endmodule
